// File: rtl/cw_pkg.sv
// cw_pkg: control-word layout, phase encoding and field encodings shared by the sequencer
package cw_pkg;
   localparam int CW_W = 33;
   localparam int ALU_EN_B = 32;
   localparam int ALU_BS_B = 31;
   localparam int ALU_FS_HI = 30;
   localparam int ALU_FS_LO = 26;
   localparam int RF_B_EN_B = 25;
   localparam int RF_SA_HI = 24;
   localparam int RF_SA_LO = 20;
   localparam int RF_SB_HI = 19;
   localparam int RF_SB_LO = 15;
   localparam int RF_DA_HI = 14;
   localparam int RF_DA_LO = 10;
   localparam int RF_W_B = 9;
   localparam int RAM_EN_B = 8;
   localparam int RAM_W_B = 7;
   localparam int PC_EN_B = 6;
   localparam int PC_FS_HI = 5;
   localparam int PC_FS_LO = 4;
   localparam int PC_IS_B = 3;
   localparam int STATUS_LD_B = 2;
   localparam int NS_HI = 1;
   localparam int NS_LO = 0;

   localparam logic [4:0] ALU_AND = 5'b00000;
   localparam logic [4:0] ALU_OR = 5'b00100;
   localparam logic [4:0] ALU_ADD = 5'b01000;

   localparam logic [1:0] PC_HOLD = 2'b00;
   localparam logic [1:0] PC_INC4 = 2'b01;

   typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} phase_t;

   typedef struct packed {
      logic       alu_en;
      logic       alu_bs;
      logic [4:0] alu_fs;
      logic       rf_b_en;
      logic [4:0] rf_sa;
      logic [4:0] rf_sb;
      logic [4:0] rf_da;
      logic       rf_w;
      logic       ram_en;
      logic       ram_w;
      logic       pc_en;
      logic [1:0] pc_fs;
      logic       pc_is;
      logic       status_ld;
   } strobe_t;
endpackage

// File: rtl/cw_unpack.sv
// cw_unpack: splits a control word into datapath strobes, next micro-state and databus-enable count
import cw_pkg::*;

module cw_unpack (
   input  logic [CW_W-1:0] cw,
   output strobe_t         strb,
   output logic [1:0]      next_state,
   output logic [2:0]      bus_cnt
);
   // pure field split; the sequencer decides whether the fields reach the outputs
   always_comb begin
      strb.alu_en    = cw[ALU_EN_B];
      strb.alu_bs    = cw[ALU_BS_B];
      strb.alu_fs    = cw[ALU_FS_HI:ALU_FS_LO];
      strb.rf_b_en   = cw[RF_B_EN_B];
      strb.rf_sa     = cw[RF_SA_HI:RF_SA_LO];
      strb.rf_sb     = cw[RF_SB_HI:RF_SB_LO];
      strb.rf_da     = cw[RF_DA_HI:RF_DA_LO];
      strb.rf_w      = cw[RF_W_B];
      strb.ram_en    = cw[RAM_EN_B];
      strb.ram_w     = cw[RAM_W_B];
      strb.pc_en     = cw[PC_EN_B];
      strb.pc_fs     = cw[PC_FS_HI:PC_FS_LO];
      strb.pc_is     = cw[PC_IS_B];
      strb.status_ld = cw[STATUS_LD_B];
      next_state     = cw[NS_HI:NS_LO];
      bus_cnt        = 3'(cw[ALU_EN_B]) + 3'(cw[RF_B_EN_B]) + 3'(cw[RAM_EN_B]) + 3'(cw[PC_EN_B]);
   end
endmodule

// File: rtl/cw_sequencer.sv
// cw_sequencer: fetches instructions into IR and steps them through decoder control words
import cw_pkg::*;

module cw_sequencer #(
   parameter int MAX_STEPS = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic [32:0] cw_in,
   output logic [31:0] ir,
   output logic [1:0]  state,
   output logic        alu_en,
   output logic        alu_bs,
   output logic [4:0]  alu_fs,
   output logic        rf_b_en,
   output logic [4:0]  rf_sa,
   output logic [4:0]  rf_sb,
   output logic [4:0]  rf_da,
   output logic        rf_w,
   output logic        ram_en,
   output logic        ram_w,
   output logic        pc_en,
   output logic [1:0]  pc_fs,
   output logic        pc_is,
   output logic        status_ld,
   output logic        bus_conflict,
   output logic        timeout
);
   localparam logic [2:0] LAST_STEP = 3'(MAX_STEPS - 1);

   phase_t      phase_q, phase_d;
   logic [31:0] ir_q, ir_d;
   logic [1:0]  state_q, state_d;
   logic [2:0]  step_q, step_d;
   strobe_t     strb_q, strb_d;
   logic        timeout_q, timeout_d;
   logic        bus_conflict_q, bus_conflict_d;
   logic        live_q;

   strobe_t     cw_strb;
   logic [1:0]  cw_ns;
   logic [2:0]  cw_bus_cnt;

   cw_unpack u_unpack (
      .cw         (cw_in),
      .strb       (cw_strb),
      .next_state (cw_ns),
      .bus_cnt    (cw_bus_cnt)
   );

   // live_q keeps the fetch request low while reset is held and until the first edge after it
   assign imem_req = live_q && phase_q == FETCH && !stall;

   // next-state: fetch handshake, one execute step per unstalled cycle, watchdog abort
   always_comb begin
      phase_d        = phase_q;
      ir_d           = ir_q;
      state_d        = state_q;
      step_d         = step_q;
      strb_d         = '0;
      timeout_d      = 1'b0;
      bus_conflict_d = bus_conflict_q;
      if (phase_q == FETCH) begin
         if (imem_req && imem_valid) begin
            ir_d    = imem_rdata;
            state_d = 2'b00;
            step_d  = 3'd0;
            phase_d = EXEC;
         end
      end else if (!stall) begin
         strb_d         = cw_strb;
         state_d        = cw_ns;
         step_d         = step_q + 3'd1;
         bus_conflict_d = bus_conflict_q || cw_bus_cnt > 3'd1;
         if (cw_ns == 2'b00) begin
            phase_d = FETCH;
         end else if (step_q == LAST_STEP) begin
            phase_d          = FETCH;
            state_d          = 2'b00;
            strb_d.rf_w      = 1'b0;
            strb_d.ram_w     = 1'b0;
            strb_d.status_ld = 1'b0;
            timeout_d        = 1'b1;
         end
      end
   end

   // all sequencer state and registered outputs, cleared asynchronously
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase_q        <= FETCH;
         ir_q           <= '0;
         state_q        <= '0;
         step_q         <= '0;
         strb_q         <= '0;
         timeout_q      <= 1'b0;
         bus_conflict_q <= 1'b0;
         live_q         <= 1'b0;
      end else begin
         phase_q        <= phase_d;
         ir_q           <= ir_d;
         state_q        <= state_d;
         step_q         <= step_d;
         strb_q         <= strb_d;
         timeout_q      <= timeout_d;
         bus_conflict_q <= bus_conflict_d;
         live_q         <= 1'b1;
      end
   end

   assign ir           = ir_q;
   assign state        = state_q;
   assign alu_en       = strb_q.alu_en;
   assign alu_bs       = strb_q.alu_bs;
   assign alu_fs       = strb_q.alu_fs;
   assign rf_b_en      = strb_q.rf_b_en;
   assign rf_sa        = strb_q.rf_sa;
   assign rf_sb        = strb_q.rf_sb;
   assign rf_da        = strb_q.rf_da;
   assign rf_w         = strb_q.rf_w;
   assign ram_en       = strb_q.ram_en;
   assign ram_w        = strb_q.ram_w;
   assign pc_en        = strb_q.pc_en;
   assign pc_fs        = strb_q.pc_fs;
   assign pc_is        = strb_q.pc_is;
   assign status_ld    = strb_q.status_ld;
   assign timeout      = timeout_q;
   assign bus_conflict = bus_conflict_q;
endmodule

// File: tb/tb_cw_sequencer.sv
// tb_cw_sequencer: directed scoreboard bench for the control-word sequencer
module tb_cw_sequencer;
   localparam logic [32:0] CW1 = {1'b1, 1'b1, 5'b00000, 1'b0, 5'd7, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01};
   localparam logic [32:0] CW2 = {1'b0, 1'b1, 5'b00100, 1'b0, 5'd7, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00};
   localparam logic [32:0] CWL = {1'b1, 1'b0, 5'b01000, 1'b0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01};
   localparam logic [32:0] CWC = {1'b1, 1'b0, 5'b01000, 1'b0, 5'd1, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
   localparam logic [32:0] CWN = {1'b0, 1'b0, 5'b00000, 1'b1, 5'd9, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
   localparam logic [32:0] WD_MASK = ~33'h284;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        imem_req, imem_valid, stall;
   logic [31:0] imem_rdata, ir;
   logic [32:0] cw_in;
   logic [1:0]  state, pc_fs;
   logic        alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_en, pc_is, status_ld;
   logic [4:0]  alu_fs, rf_sa, rf_sb, rf_da;
   logic        bus_conflict, timeout;
   logic [32:0] obs;
   int          mode;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      string       tag;
      logic [32:0] strb;
      logic        to;
   } exp_t;
   exp_t sb[$];

   always #5 clock = ~clock;

   cw_sequencer #(.MAX_STEPS(4)) dut (
      .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_valid(imem_valid),
      .imem_rdata(imem_rdata), .stall(stall), .cw_in(cw_in), .ir(ir), .state(state),
      .alu_en(alu_en), .alu_bs(alu_bs), .alu_fs(alu_fs), .rf_b_en(rf_b_en),
      .rf_sa(rf_sa), .rf_sb(rf_sb), .rf_da(rf_da), .rf_w(rf_w), .ram_en(ram_en),
      .ram_w(ram_w), .pc_en(pc_en), .pc_fs(pc_fs), .pc_is(pc_is), .status_ld(status_ld),
      .bus_conflict(bus_conflict), .timeout(timeout)
   );

   // decoder model: MOVK is state dependent, the others return a fixed word
   always_comb cw_in = mode == 0 ? (state == 2'b00 ? CW1 : CW2) : mode == 1 ? CWL : mode == 2 ? CWC : CWN;

   assign obs = {alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb, rf_da, rf_w, ram_en, ram_w, pc_en, pc_fs, pc_is, status_ld, 2'b00};

   function automatic logic [32:0] strobes(input logic [32:0] cw);
      return {cw[32:2], 2'b00};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic cyc(input string tag, input logic [32:0] strb, input logic to);
      exp_t e;
      sb.push_back('{tag, strb, to});
      @(posedge clock);
      @(negedge clock);
      e = sb.pop_front();
      chk({e.tag, "_strb"}, 64'(obs), 64'(e.strb));
      chk({e.tag, "_to"}, 64'(timeout), 64'(e.to));
   endtask

   task automatic fetch(input logic [31:0] w);
      imem_valid = 1'b1;
      imem_rdata = w;
      chk("fetch_req", 64'(imem_req), 64'd1);
      cyc("fetch", 33'd0, 1'b0);
      imem_valid = 1'b0;
      chk("fetch_ir", 64'(ir), 64'(w));
      chk("fetch_state", 64'(state), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      reset_n = 1'b1;
      stall = 1'b0;
      imem_valid = 1'b0;
      imem_rdata = '0;
      mode = 0;
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_strb", 64'(obs), 64'd0);
      chk("rst_req", 64'(imem_req), 64'd0);
      chk("rst_ir", 64'(ir), 64'd0);
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_to", 64'(timeout), 64'd0);
      chk("rst_conf", 64'(bus_conflict), 64'd0);
      reset_n = 1'b1;
      cyc("c1", 33'd0, 1'b0);
      chk("c1_req", 64'(imem_req), 64'd1);
      cyc("c2", 33'd0, 1'b0);
      chk("c2_req", 64'(imem_req), 64'd1);
      imem_valid = 1'b1;
      imem_rdata = 32'hF2A0_0123;
      chk("c3_req", 64'(imem_req), 64'd1);
      cyc("c3", 33'd0, 1'b0);
      chk("hs_ir", 64'(ir), 64'hF2A0_0123);
      chk("hs_state", 64'(state), 64'd0);
      chk("hs_req_exec", 64'(imem_req), 64'd0);
      imem_rdata = 32'hDEAD_BEEF;
      cyc("movk_s0", strobes(CW1), 1'b0);
      chk("movk_s0_state", 64'(state), 64'd1);
      chk("movk_s0_pcfs", 64'(pc_fs), 64'd0);
      chk("movk_ir_hold", 64'(ir), 64'hF2A0_0123);
      imem_valid = 1'b0;
      cyc("movk_s1", strobes(CW2), 1'b0);
      chk("movk_s1_pcfs", 64'(pc_fs), 64'd1);
      chk("movk_s1_rfw", 64'(rf_w), 64'd1);
      chk("movk_s1_state", 64'(state), 64'd0);
      chk("movk_req", 64'(imem_req), 64'd1);
      cyc("movk_end", 33'd0, 1'b0);
      fetch(32'h1234_5678);
      cyc("st_s0", strobes(CW1), 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc("st_hold", 33'd0, 1'b0);
         chk("st_hold_state", 64'(state), 64'd1);
      end
      stall = 1'b0;
      cyc("st_resume", strobes(CW2), 1'b0);
      chk("st_resume_state", 64'(state), 64'd0);
      stall = 1'b1;
      #1 chk("st_fetch_req", 64'(imem_req), 64'd0);
      imem_valid = 1'b1;
      imem_rdata = 32'hAAAA_5555;
      cyc("st_fetch", 33'd0, 1'b0);
      chk("st_fetch_ir", 64'(ir), 64'h1234_5678);
      stall = 1'b0;
      imem_valid = 1'b0;
      #1 chk("st_fetch_req_back", 64'(imem_req), 64'd1);
      mode = 1;
      @(negedge clock);
      fetch(32'h0BAD_F00D);
      for (int i = 0; i < 3; i++) begin
         cyc("wd_step", strobes(CWL), 1'b0);
         chk("wd_step_state", 64'(state), 64'd1);
      end
      cyc("wd_abort", strobes(CWL) & WD_MASK, 1'b1);
      chk("wd_abort_rfw", 64'(rf_w), 64'd0);
      chk("wd_abort_state", 64'(state), 64'd0);
      chk("wd_abort_req", 64'(imem_req), 64'd1);
      cyc("wd_after", 33'd0, 1'b0);
      chk("cf_before", 64'(bus_conflict), 64'd0);
      mode = 2;
      fetch(32'hC0FF_0001);
      cyc("cf_step", strobes(CWC), 1'b0);
      cyc("cf_end", 33'd0, 1'b0);
      chk("cf_set", 64'(bus_conflict), 64'd1);
      mode = 3;
      for (int i = 0; i < 10; i++) begin
         fetch(32'h5000_0000 + 32'(i));
         cyc("clean", strobes(CWN), 1'b0);
         cyc("clean_end", 33'd0, 1'b0);
      end
      chk("cf_sticky", 64'(bus_conflict), 64'd1);
      mode = 0;
      fetch(32'h7777_0001);
      cyc("ar_s0", strobes(CW1), 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_strb", 64'(obs), 64'd0);
      chk("ar_state", 64'(state), 64'd0);
      chk("ar_ir", 64'(ir), 64'd0);
      chk("ar_req", 64'(imem_req), 64'd0);
      chk("ar_conf", 64'(bus_conflict), 64'd0);
      chk("ar_to", 64'(timeout), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      cyc("ar_rel", 33'd0, 1'b0);
      chk("ar_rel_req", 64'(imem_req), 64'd1);
      chk("ar_rel_state", 64'(state), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
